// File: rtl/mem_read_arbiter_pkg.sv
// Shared types for the memory-bank read front end: request width, in-flight tag
// format and the stored fixed-point format.
package mem_read_arbiter_pkg;

  localparam int unsigned MEM_STORE_FRAC = 10;
  localparam int unsigned MEM_ID_W       = 3;
  localparam int unsigned MEM_FRAC_W     = 5;

  typedef enum logic {
    SINGLE_WIDTH = 1'b0,
    DOUBLE_WIDTH = 1'b1
  } DataWidth_t;

  typedef enum logic [1:0] {
    KIND_SINGLE = 2'd0,
    KIND_LO     = 2'd1,
    KIND_HI     = 2'd2
  } MemRdKind_t;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ID_W-1:0]   id;
    MemRdKind_t            kind;
    logic [MEM_FRAC_W-1:0] frac;
  } MemRdTag_t;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Request/response bundle between the read masters and the bank read arbiter.
interface mem_read_arbiter_if
  import mem_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned WORD_W  = 16
);

  logic       [NUM_REQ-1:0]                 req_en;
  logic       [NUM_REQ-1:0][ADDR_W-1:0]     req_addr;
  DataWidth_t [NUM_REQ-1:0]                 req_width;
  logic       [NUM_REQ-1:0][MEM_FRAC_W-1:0] req_frac;
  logic       [NUM_REQ-1:0]                 req_gnt;
  logic       [NUM_REQ-1:0]                 rsp_valid;
  logic       [2*WORD_W-1:0]                rsp_data;

  modport master (
    output req_en, req_addr, req_width, req_frac,
    input  req_gnt, rsp_valid, rsp_data
  );

  modport slave (
    input  req_en, req_addr, req_width, req_frac,
    output req_gnt, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: highest priority at the pointer, ascending with wrap;
// the pointer moves past the winner only when advance_i is set.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_c
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic             found;

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    gnt_c = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req_i[i] && (PTR_W'(i) >= ptr_q)) begin
        found    = 1'b1;
        gnt_c[i] = 1'b1;
        ptr_d    = (i == int'(N) - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_c[i] = 1'b1;
        ptr_d    = (i == int'(N) - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Read front end for one single-port bank: round-robin arbitration, double-width
// split into lo/hi accesses, tagged return path with fixed-point recast of singles.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned BANK_LAT   = 1,
  parameter int unsigned STORE_FRAC = MEM_STORE_FRAC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_read_arbiter_if.slave rd_bus,
  output logic              bank_en_o,
  output logic [ADDR_W-1:0] bank_addr_o,
  input  logic [WORD_W-1:0] bank_data_i
);

  localparam int unsigned RSP_W = 2 * WORD_W;
  localparam int unsigned DEPTH = BANK_LAT + 1;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_HI  = 1'b1
  } state_t;

  state_t                  state_q;
  logic [MEM_ID_W-1:0]     owner_q;
  logic [ADDR_W-1:0]       hi_addr_q;
  logic [WORD_W-1:0]       held_lo_q;
  MemRdTag_t               tag_q [DEPTH];
  logic                    bank_en_q;
  logic [ADDR_W-1:0]       bank_addr_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [RSP_W-1:0]        rsp_data_q;

  logic [NUM_REQ-1:0]      arb_req;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic                    arb_adv;
  logic [NUM_REQ-1:0]      gnt_c;
  logic                    win_c;
  logic [MEM_ID_W-1:0]     win_id_c;
  logic [ADDR_W-1:0]       win_addr_c;
  DataWidth_t              win_width_c;
  logic [MEM_FRAC_W-1:0]   win_frac_c;

  // Sign-extend and rescale a stored word to the requester's fractional bits.
  function automatic logic [RSP_W-1:0] cast_word(input logic [WORD_W-1:0]     w,
                                                  input logic [MEM_FRAC_W-1:0] frac);
    logic signed [RSP_W-1:0] ext;
    int                      d;
    ext = RSP_W'($signed(w));
    d   = int'(frac) - int'(STORE_FRAC);
    if (d >= 0) begin
      return ext <<< d;
    end
    return ext >>> (-d);
  endfunction

  // The hi issue cycle and reset both suppress arbitration.
  always_comb begin
    arb_req = (state_q == ST_ARB && !rst_i) ? rd_bus.req_en : '0;
    arb_adv = (state_q == ST_ARB) && !rst_i;
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (arb_req),
    .advance_i (arb_adv),
    .gnt_c     (arb_gnt)
  );

  always_comb begin
    win_c       = |arb_gnt;
    win_id_c    = '0;
    win_addr_c  = '0;
    win_width_c = SINGLE_WIDTH;
    win_frac_c  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (arb_gnt[i]) begin
        win_id_c    = MEM_ID_W'(i);
        win_addr_c  = rd_bus.req_addr[i];
        win_width_c = rd_bus.req_width[i];
        win_frac_c  = rd_bus.req_frac[i];
      end
    end
  end

  // A grant marks the request's final bank read: singles at once, doubles in the hi cycle.
  always_comb begin
    gnt_c = '0;
    if (!rst_i) begin
      if (state_q == ST_HI) begin
        gnt_c = NUM_REQ'(1) << owner_q;
      end else begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          gnt_c[i] = arb_gnt[i] && (rd_bus.req_width[i] == SINGLE_WIDTH);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_ARB;
      owner_q     <= '0;
      hi_addr_q   <= '0;
      held_lo_q   <= '0;
      bank_en_q   <= 1'b0;
      bank_addr_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      bank_en_q   <= 1'b0;
      rsp_valid_q <= '0;
      tag_q[0]    <= '0;
      for (int k = 1; k < int'(DEPTH); k++) begin
        tag_q[k] <= tag_q[k-1];
      end

      case (state_q)
        ST_ARB: begin
          if (win_c) begin
            bank_en_q   <= 1'b1;
            bank_addr_q <= win_addr_c;
            if (win_width_c == DOUBLE_WIDTH) begin
              tag_q[0]  <= '{valid: 1'b1, id: win_id_c, kind: KIND_LO, frac: win_frac_c};
              owner_q   <= win_id_c;
              hi_addr_q <= win_addr_c + ADDR_W'(1);
              state_q   <= ST_HI;
            end else begin
              tag_q[0]  <= '{valid: 1'b1, id: win_id_c, kind: KIND_SINGLE, frac: win_frac_c};
            end
          end
        end
        ST_HI: begin
          bank_en_q   <= 1'b1;
          bank_addr_q <= hi_addr_q;
          tag_q[0]    <= '{valid: 1'b1, id: owner_q, kind: KIND_HI, frac: '0};
          state_q     <= ST_ARB;
        end
        default: state_q <= ST_ARB;
      endcase

      // Retire the tag whose bank data is present this cycle.
      if (tag_q[BANK_LAT].valid) begin
        case (tag_q[BANK_LAT].kind)
          KIND_SINGLE: begin
            rsp_valid_q <= NUM_REQ'(1) << tag_q[BANK_LAT].id;
            rsp_data_q  <= cast_word(bank_data_i, tag_q[BANK_LAT].frac);
          end
          KIND_LO: begin
            held_lo_q <= bank_data_i;
          end
          KIND_HI: begin
            rsp_valid_q <= NUM_REQ'(1) << tag_q[BANK_LAT].id;
            rsp_data_q  <= {bank_data_i, held_lo_q};
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_bus.req_gnt   = gnt_c;
  assign rd_bus.rsp_valid = rsp_valid_q;
  assign rd_bus.rsp_data  = rsp_data_q;
  assign bank_en_o        = bank_en_q;
  assign bank_addr_o      = bank_addr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios then random traffic, each cycle
// compared against a transaction-level reference of arbitration and data return.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned WW = 16;
  localparam int unsigned BL = 1;
  localparam int          SF = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          bank_en;
  logic [AW-1:0] bank_addr;
  logic [WW-1:0] bank_data;

  always #5 clk = ~clk;

  mem_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .WORD_W(WW)) bus ();

  mem_read_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .WORD_W(WW), .BANK_LAT(BL), .STORE_FRAC(SF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rd_bus      (bus),
    .bank_en_o   (bank_en),
    .bank_addr_o (bank_addr),
    .bank_data_i (bank_data)
  );

  // Bank model: data appears BL cycles after the enable cycle.
  logic [WW-1:0] mem  [65536];
  logic [WW-1:0] pipe [BL];
  always @(posedge clk) begin
    pipe[0] <= mem[bank_addr];
    for (int k = 1; k < int'(BL); k++) pipe[k] <= pipe[k-1];
  end
  assign bank_data = pipe[BL-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;

  int          total, bad, cyc;
  int          ptr, hi_owner;
  bit          hi_pend, exp_ben;
  logic [15:0] hi_addr, lo_addr, exp_baddr;
  rsp_t        expq[$];

  int          gnt_cyc[NR], rsp_cyc[NR], gnt_cnt[NR];
  logic [31:0] rsp_dat[NR];
  int          gq[$], rq[$];
  int          rsp_seen, ben_cnt;
  logic [NR-1:0] last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference recast: value * 2^d, or floor division by 2^-d.
  function automatic logic [31:0] ref_cast(input logic [15:0] w, input int frac);
    longint v, p, q;
    int     d;
    v = longint'($signed(w));
    d = frac - SF;
    if (d >= 0) begin
      v = v * (longint'(1) << d);
    end else begin
      p = longint'(1) << (-d);
      q = v / p;
      if ((v % p) != 0 && v < 0) q = q - 1;
      v = q;
    end
    return 32'(v);
  endfunction

  task automatic tick();
    logic [NR-1:0] eg, erv;
    logic [31:0]   erd;
    bit            nben, nhi;
    logic [15:0]   nbaddr, a;
    rsp_t          r;
    int            w, idx;
    eg = '0; erv = '0; erd = '0; nben = 1'b0; nhi = 1'b0; nbaddr = exp_baddr; w = -1;
    if (!rst) begin
      if (hi_pend) begin
        eg[hi_owner] = 1'b1;
        nben = 1'b1; nbaddr = hi_addr;
        r.due = cyc + int'(BL) + 2; r.id = hi_owner; r.data = {mem[hi_addr], mem[lo_addr]};
        expq.push_back(r);
      end else begin
        for (int k = 0; k < int'(NR); k++) begin
          idx = (ptr + k) % int'(NR);
          if (w < 0 && bus.req_en[idx]) w = idx;
        end
        if (w >= 0) begin
          ptr = (w + 1) % int'(NR);
          a = bus.req_addr[w];
          nben = 1'b1; nbaddr = a;
          if (bus.req_width[w] == SINGLE_WIDTH) begin
            eg[w] = 1'b1;
            r.due = cyc + int'(BL) + 2; r.id = w;
            r.data = ref_cast(mem[a], int'(bus.req_frac[w]));
            expq.push_back(r);
          end else begin
            nhi = 1'b1; hi_owner = w; lo_addr = a; hi_addr = a + 16'd1;
          end
        end
      end
    end
    if (expq.size() > 0 && expq[0].due == cyc) begin
      erv = NR'(1) << expq[0].id;
      erd = expq[0].data;
    end

    @(negedge clk);
    chk("req_gnt", 64'(bus.req_gnt), 64'(eg));
    chk("bank_en", 64'(bank_en), 64'(exp_ben));
    if (exp_ben) chk("bank_addr", 64'(bank_addr), 64'(exp_baddr));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(erv));
    if (erv != '0) begin
      chk("rsp_data", 64'(bus.rsp_data), 64'(erd));
      void'(expq.pop_front());
    end
    last_gnt = bus.req_gnt;
    if (bank_en) ben_cnt++;
    for (int i = 0; i < int'(NR); i++) begin
      if (bus.req_gnt[i]) begin gnt_cyc[i] = cyc; gnt_cnt[i]++; gq.push_back(i); end
      if (bus.rsp_valid[i]) begin rsp_cyc[i] = cyc; rsp_dat[i] = bus.rsp_data; rsp_seen++; rq.push_back(i); end
    end

    @(posedge clk); #1;
    if (rst) begin
      ptr = 0; hi_pend = 1'b0; expq.delete(); exp_ben = 1'b0; exp_baddr = '0;
    end else begin
      exp_ben = nben; exp_baddr = nbaddr; hi_pend = nhi;
    end
    cyc++;
  endtask

  task automatic clear_req();
    bus.req_en = '0;
    for (int i = 0; i < int'(NR); i++) begin
      bus.req_addr[i] = '0; bus.req_width[i] = SINGLE_WIDTH; bus.req_frac[i] = 5'(SF);
    end
  endtask

  task automatic set_req(input int m, input logic [15:0] a, input DataWidth_t wd, input int frac);
    bus.req_addr[m] = a; bus.req_width[m] = wd; bus.req_frac[m] = 5'(frac); bus.req_en[m] = 1'b1;
  endtask

  int saved;

  initial begin
    total = 0; bad = 0; cyc = 0; ptr = 0; hi_pend = 1'b0; exp_ben = 1'b0; exp_baddr = '0;
    rsp_seen = 0; ben_cnt = 0; hi_owner = 0; hi_addr = '0; lo_addr = '0;
    for (int i = 0; i < int'(NR); i++) begin gnt_cyc[i] = 0; rsp_cyc[i] = 0; gnt_cnt[i] = 0; rsp_dat[i] = '0; end
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    rst = 1'b1; clear_req();
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;

    // Idle after reset.
    repeat (10) tick();
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
    chk("rst_bank_addr", 64'(bank_addr), 64'h0);
    chk("idle_no_bank_en", 64'(ben_cnt), 64'd0);

    // Single-width recasts.
    mem[16'h0010] = 16'h0400;
    set_req(0, 16'h0010, SINGLE_WIDTH, 10); tick(); bus.req_en[0] = 1'b0; repeat (5) tick();
    chk("single_f10", 64'(rsp_dat[0]), 64'h0000_0400);
    chk("single_lat", 64'(rsp_cyc[0] - gnt_cyc[0]), 64'(BL + 2));
    set_req(0, 16'h0010, SINGLE_WIDTH, 14); tick(); bus.req_en[0] = 1'b0; repeat (5) tick();
    chk("single_f14", 64'(rsp_dat[0]), 64'h0000_4000);
    mem[16'h0010] = 16'hFC00;
    set_req(0, 16'h0010, SINGLE_WIDTH, 6); tick(); bus.req_en[0] = 1'b0; repeat (5) tick();
    chk("single_f6_neg", 64'(rsp_dat[0]), 64'hFFFF_FFC0);

    // Three masters streaming singles from reset.
    rst = 1'b1; tick(); rst = 1'b0;
    gq.delete(); rq.delete();
    for (int i = 0; i < int'(NR); i++) set_req(i, 16'(16'h0100 + i), SINGLE_WIDTH, 4 + 3 * i);
    repeat (6) tick();
    clear_req(); repeat (5) tick();
    chk("rr_gnt_count", 64'(gq.size()), 64'd6);
    chk("rr_rsp_count", 64'(rq.size()), 64'd6);
    for (int k = 0; k < 6 && k < gq.size() && k < rq.size(); k++) begin
      chk("rr_gnt_order", 64'(gq[k]), 64'(k % 3));
      chk("rr_rsp_order", 64'(rq[k]), 64'(k % 3));
    end

    // Double-width read across the address wrap with a competing single.
    mem[16'hFFFF] = 16'h1234; mem[16'h0000] = 16'hABCD;
    gq.delete();
    set_req(1, 16'hFFFF, DOUBLE_WIDTH, 10);
    set_req(2, 16'h0020, SINGLE_WIDTH, 10);
    tick(); tick();
    bus.req_en[1] = 1'b0;
    tick();
    bus.req_en[2] = 1'b0;
    repeat (5) tick();
    chk("dbl_data", 64'(rsp_dat[1]), 64'hABCD_1234);
    chk("dbl_then_m2", 64'(gnt_cyc[2] - gnt_cyc[1]), 64'd1);
    chk("dbl_gnt_count", 64'(gq.size()), 64'd2);

    // Withdrawn request while another master owns the bank.
    saved = gnt_cnt[2]; ben_cnt = 0;
    set_req(0, 16'h0030, DOUBLE_WIDTH, 10);
    set_req(2, 16'h0040, SINGLE_WIDTH, 10);
    tick(); tick();
    clear_req(); repeat (5) tick();
    chk("withdraw_no_gnt", 64'(gnt_cnt[2] - saved), 64'd0);
    chk("withdraw_bank_reads", 64'(ben_cnt), 64'd2);

    // Reset with two reads in flight, then pointer back at master 0.
    set_req(1, 16'h0050, SINGLE_WIDTH, 10); tick(); bus.req_en[1] = 1'b0;
    set_req(0, 16'h0060, SINGLE_WIDTH, 10); tick(); bus.req_en[0] = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    saved = rsp_seen;
    repeat (8) tick();
    chk("rst_drop_rsp", 64'(rsp_seen - saved), 64'd0);
    for (int i = 0; i < int'(NR); i++) set_req(i, 16'(16'h0070 + i), SINGLE_WIDTH, 10);
    tick();
    chk("rst_ptr_gnt", 64'(last_gnt), 64'(3'b001));
    clear_req(); repeat (5) tick();

    // Random traffic with rare resets.
    repeat (3000) begin
      for (int i = 0; i < int'(NR); i++) begin
        bus.req_en[i]    = ($urandom_range(0, 99) < 60);
        bus.req_addr[i]  = 16'($urandom);
        bus.req_width[i] = ($urandom_range(0, 1) == 0) ? SINGLE_WIDTH : DOUBLE_WIDTH;
        bus.req_frac[i]  = 5'($urandom_range(SF - 8, SF + 16));
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; clear_req();
    repeat (8) tick();
    chk("drain_empty", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Read-side front end of the centralized memory subsystem. It sits between up to `NUM_REQ` compute-side read masters and one single-port memory bank's read port. It arbitrates round-robin, splits double-width reads into two bank accesses and retags the returning data. Single-width words are cast from the stored fixed-point format to the requester's format before being returned.

## Interface
Parameters:
- `NUM_REQ`, 3, number of read masters (2..8).
- `ADDR_W`, 16, bank word address width.
- `WORD_W`, 16, stored word width; double-width reads return `2*WORD_W`.
- `BANK_LAT`, 1, bank read latency in cycles (`bank_en` to `bank_data`), 1..3.
- `STORE_FRAC`, 10, fractional bits of stored single-width words.

Ports:
- `clk  in  1  clock`
- `rst  in  1  reset, synchronous and active-high`
- `req_en  in  NUM_REQ  read request per master, level, held until granted`
- `req_addr  in  NUM_REQ x ADDR_W  word address`
- `req_width  in  NUM_REQ x DataWidth_t  SINGLE_WIDTH or DOUBLE_WIDTH`
- `req_frac  in  NUM_REQ x 5  requested fractional bits (single only); legal STORE_FRAC-8 .. STORE_FRAC+16`
- `req_gnt  out  NUM_REQ  one-hot, one-cycle pulse when the request's final bank read issues`
- `rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse with rsp_data`
- `rsp_data  out  2*WORD_W  shared response data`
- `bank_en  out  1  bank read enable (registered)`
- `bank_addr  out  ADDR_W  bank read address (registered)`
- `bank_data  in  WORD_W  bank read data, valid BANK_LAT cycles after bank_en`

## Operation
- FSM states:
  - `ARB` (reset state).
  - `HI`.
- `ARB`:
  - Picks the winner among asserted `req_en` using a round-robin pointer (reset 0). Highest priority goes to the pointer index, then ascending with wrap.
  - A winner makes the pointer advance to winner+1 (mod `NUM_REQ`). No winner leaves the pointer unchanged.
- Single-width win:
  - Assert `req_gnt[w]` in the same cycle.
  - Issue the read of `addr`.
  - Stay in `ARB`.
- Double-width win:
  - Latch `w` and `addr`; no `req_gnt`.
  - Issue the read of `addr` (lo).
  - Go to `HI`.
- `HI`:
  - Issue the read of `addr+1` (hi; address wraps from `2^ADDR_W-1` to 0).
  - Assert `req_gnt[w]`.
  - Return to `ARB`.
  - No arbitration takes place in this state.
  - The owner's inputs are ignored; other masters wait.
- Tag pipeline:
  - Depth `BANK_LAT+1`.
  - Each stage carries valid, requester id, kind (SINGLE/LO/HI) and frac.
  - Tags advance every cycle.
- Return, single:
  - Sign-extend the word to 32 bits, then shift by `d = req_frac - STORE_FRAC`.
  - `d>0`: shift left by d. `d<0`: arithmetic right shift by -d, truncating toward -inf. No saturation: the legal range cannot overflow.
- Return, LO: store the word in a holding register; no response.
- Return, HI: `rsp_data = {hi, held_lo}`, raw with no cast.
- A master that drops `req_en` before its grant has withdrawn the request (legal). Changing the request inputs while ungranted is legal; the values sampled in the winning cycle are used.
- A new request from the same master may be presented the cycle after `req_gnt`.

## Timing
- Winner in cycle t:
  - `bank_en`/`bank_addr` high/valid in t+1.
  - Data returns in t+1+`BANK_LAT`.
  - `rsp_valid`/`rsp_data` registered in t+2+`BANK_LAT`.
- Latency from `req_gnt` to `rsp_valid`:
  - Single: `BANK_LAT+2` cycles.
  - Double: `BANK_LAT+2` cycles from its `req_gnt` (the `HI` cycle).
- Throughput:
  - One single per cycle sustained.
  - A double occupies 2 issue cycles.
- Responses return in grant order; at most one `rsp_valid` bit is set per cycle.
- Reset values:
  - `req_gnt`=0, `rsp_valid`=0, `rsp_data`=0, `bank_en`=0, `bank_addr`=0.
  - FSM=`ARB`, pointer=0, tag pipeline invalid, holding register=0.
- Reset mid-operation: all in-flight reads are dropped. No `rsp_valid` appears after reset deasserts for any pre-reset request.
- `bank_en` is never high in a cycle whose issue lacks a winner.

## Structure
- Shared package `Defines`:
  - Reuses `DataWidth_t`.
  - Adds `MemRdKind_t` enum (SINGLE, LO, HI).
  - Adds `MemRdTag_t` struct (valid, id, kind, frac).
  - Adds the constant `MEM_STORE_FRAC`.
- Sub-module `rr_arbiter`:
  - Parameter `N`; inputs `req[N]`, `advance`; output one-hot `gnt[N]`.
  - Owns the pointer register.
- The cast is a local function inside `mem_read_arbiter`.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, `bank_en` never asserted.
- Master 0 single, addr 0x0010, frac 10, bank word 0x0400 -> `rsp_valid[0]` with `rsp_data`=0x00000400, `BANK_LAT+2` cycles after `req_gnt[0]`. Repeat with frac 14 (0x00004000) and frac 6, word 0xFC00 (0xFFFFFFC0).
- All 3 masters request singles continuously from reset -> grants 0,1,2,0,1,2 on consecutive cycles; responses in the same order, one per cycle.
- Master 1 double at addr 0xFFFF, bank[0xFFFF]=0x1234, bank[0x0000]=0xABCD -> `bank_addr` 0xFFFF then 0x0000; `rsp_data`=0xABCD1234. Master 2's concurrent request is granted no earlier than the cycle after `HI`.
- Master 2 raises `req_en` while master 0 holds the pointer, then drops it before being granted -> no `req_gnt[2]`, no bank read for it.
- Assert `rst` one cycle after 2 grants are issued -> no `rsp_valid` afterward; the next request is served normally with the pointer at 0.
